// File: rtl/echo_rd_pkg.sv
// Shared types and constants for the echo sample buffer readout sequencer.
package echo_rd_pkg;

    localparam int ADDR_W = 12;   // width of the external read-address counter
    localparam int LAT_W  = 2;    // holds RAM_LAT-1 for RAM_LAT in 1..3

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_WAIT,
        ST_CAPT,
        ST_XFER,
        ST_STEP,
        ST_CKS,
        ST_DONE
    } state_e;

endpackage

// File: rtl/echo_rd_cksum.sv
// Running sum of transferred data words, cleared when a readout starts.
module echo_rd_cksum #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              add_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] sum_o
);

    logic [DATA_W-1:0] acc_q;

    // Sum including the word being added this cycle; wraps mod 2^DATA_W.
    assign sum_o = acc_q + data_i;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (add_i) begin
            acc_q <= sum_o;
        end
    end

endmodule

// File: rtl/echo_rd_seq.sv
// Readout sequencer: steps the external address counter, captures RAM words and streams them out.
// Define ECHO_RD_CKSUM_EN to append a checksum word to every frame.
module echo_rd_seq
    import echo_rd_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] n_words,
    output logic              addr_rst,
    output logic              addr_clk,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RAM_LAT - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] last_idx_q, last_idx_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              addr_rst_q, addr_rst_d;
    logic              addr_clk_q, addr_clk_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              xfer;

    assign xfer = valid_q && out_ready;

`ifdef ECHO_RD_CKSUM_EN
    logic [DATA_W-1:0] cks_sum;

    echo_rd_cksum #(.DATA_W(DATA_W)) u_cksum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q == ST_IDLE && start),
        .add_i  (state_q == ST_XFER && xfer),
        .data_i (data_q),
        .sum_o  (cks_sum)
    );
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        last_idx_d = last_idx_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        data_d     = data_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    last_idx_d = n_words - ADDR_W'(1);
                    cnt_d      = '0;
                    state_d    = ST_CLR;
                end
            end
            ST_CLR: begin
                lat_d   = LAT_INIT;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_q == '0) state_d = ST_CAPT;
                else             lat_d   = lat_q - LAT_W'(1);
            end
            ST_CAPT: begin
                data_d  = ram_dout;
                state_d = ST_XFER;
            end
            ST_XFER: begin
                if (xfer) begin
                    if (cnt_q == last_idx_q) begin
`ifdef ECHO_RD_CKSUM_EN
                        data_d  = cks_sum;
                        state_d = ST_CKS;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        cnt_d   = cnt_q + ADDR_W'(1);
                        state_d = ST_STEP;
                    end
                end
            end
            ST_STEP: begin
                lat_d   = LAT_INIT;
                state_d = ST_WAIT;
            end
`ifdef ECHO_RD_CKSUM_EN
            ST_CKS: begin
                if (xfer) state_d = ST_DONE;
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so each one leaves a flop.
        valid_d    = (state_d == ST_XFER) || (state_d == ST_CKS);
`ifdef ECHO_RD_CKSUM_EN
        last_d     = (state_d == ST_CKS);
`else
        last_d     = (state_d == ST_XFER) && (cnt_d == last_idx_d);
`endif
        addr_rst_d = (state_d inside {ST_IDLE, ST_CLR, ST_DONE});
        addr_clk_d = (state_d == ST_STEP);
        busy_d     = !(state_d inside {ST_IDLE, ST_DONE});
        done_d     = (state_d == ST_DONE);
    end

    // NOTE: the existing reset net keeps its rst_n name but is asserted high, asynchronously.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= ST_IDLE;
            last_idx_q <= '0;
            cnt_q      <= '0;
            lat_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            addr_rst_q <= 1'b1;
            addr_clk_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q    <= state_d;
            last_idx_q <= last_idx_d;
            cnt_q      <= cnt_d;
            lat_q      <= lat_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            addr_rst_q <= addr_rst_d;
            addr_clk_q <= addr_clk_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign addr_rst  = addr_rst_q;
    assign addr_clk  = addr_clk_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_echo_rd_seq.sv
// Self-checking bench for echo_rd_seq with a behavioural address counter and RAM model.
module tb_echo_rd_seq;

    localparam int DATA_W  = 16;
    localparam int RAM_LAT = 1;
`ifdef ECHO_RD_CKSUM_EN
    localparam int CKS_EXTRA = 1;
`else
    localparam int CKS_EXTRA = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [11:0]       n_words;
    logic              addr_rst;
    logic              addr_clk;
    logic [DATA_W-1:0] ram_dout;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    echo_rd_seq #(.DATA_W(DATA_W), .RAM_LAT(RAM_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .n_words   (n_words),
        .addr_rst  (addr_rst),
        .addr_clk  (addr_clk),
        .ram_dout  (ram_dout),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial forever #5 clk = ~clk;

    // External 12-bit counter: level reset, advances on the falling edge of addr_clk.
    logic [11:0]       ram_addr;
    logic [DATA_W-1:0] mem [4096];
    logic [DATA_W-1:0] ram_pipe [RAM_LAT];
    int                pulses = 0;

    always @(negedge addr_clk or posedge addr_rst) begin
        if (addr_rst) ram_addr <= '0;
        else          ram_addr <= ram_addr + 12'd1;
    end

    always @(negedge addr_clk) begin
        if (addr_rst === 1'b0) pulses <= pulses + 1;
    end

    always @(posedge clk) begin
        ram_pipe[0] <= mem[ram_addr];
        for (int i = 1; i < RAM_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign ram_dout = ram_pipe[RAM_LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_mem(input bit rnd);
        for (int i = 0; i < 4096; i++) mem[i] = rnd ? DATA_W'($urandom) : DATA_W'(i + 'h100);
    endtask

    // Runs one frame and compares the stream with mem[0..N-1] (plus their sum when enabled).
    // Returns at the falling edge where done is seen, i.e. while the DUT sits in DONE.
    task automatic run_frame(input logic [11:0] n, input int rdy_pct, input bit mid_start,
                             output int n_xfer, output int lat, output logic [DATA_W-1:0] last_word);
        int                dlen, total, k, k_last, p0;
        logic [DATA_W-1:0] sum, exp_w, held;
        bit                stalled, saw_done, bad_busy, bad_stall, bad_clk;
        dlen  = (n == 12'd0) ? 4096 : int'(n);
        total = dlen + CKS_EXTRA;
        sum   = '0;
        for (int i = 0; i < dlen; i++) sum = sum + mem[i];
        n_xfer = 0; lat = -1; k = 0; k_last = -100; last_word = '0; held = '0;
        stalled = 0; saw_done = 0; bad_busy = 0; bad_stall = 0; bad_clk = 0;
        p0 = pulses;
        @(negedge clk); start = 1'b1; n_words = n; out_ready = 1'b0;
        @(negedge clk); start = 1'b0;
        while (!saw_done && k < 20 * total + 100) begin
            if (done) begin
                saw_done = 1;
                check("done one cycle after last transfer", 32'(k), 32'(k_last + 1));
                check("busy low with done", 32'(busy), 32'd0);
            end else begin
                if (!busy) bad_busy = 1;
                if (stalled && (!out_valid || out_data !== held)) bad_stall = 1;
                if (addr_clk && out_valid) bad_clk = 1;
                if (out_valid && lat < 0) lat = k;
                start     = mid_start && (k == 12);
                n_words   = start ? ~n : n;
                out_ready = ($urandom_range(99) < rdy_pct);
                if (out_valid && out_ready) begin
                    exp_w = (n_xfer < dlen) ? mem[n_xfer] : sum;
                    check("word value", 32'(out_data), 32'(exp_w));
                    check("out_last", 32'(out_last), 32'(n_xfer == total - 1));
                    last_word = out_data;
                    n_xfer++;
                    k_last = k;
                end
                stalled = out_valid && !out_ready;
                held    = out_data;
                @(negedge clk);
                k++;
            end
        end
        start = 1'b0;
        check("done seen", 32'(saw_done), 32'd1);
        check("frame length", 32'(n_xfer), 32'(total));
        check("busy held through frame", 32'(bad_busy), 32'd0);
        check("data stable while stalled", 32'(bad_stall), 32'd0);
        check("no addr_clk while word pending", 32'(bad_clk), 32'd0);
        check("addr_clk pulse count", 32'(pulses - p0), 32'(dlen - 1));
        check("counter back at 0", 32'(ram_addr), 32'd0);
    endtask

    typedef struct {
        logic [11:0]       n;
        int                rdy_pct;
        bit                rand_mem;
        bit                mid_start;
        int                exp_len;
        int                exp_lat;
        bit                chk_last;
        logic [DATA_W-1:0] exp_last;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int                n_x, lat, wait_cnt;
        logic [DATA_W-1:0] lw;
        bit                bad_done;

        vecs[0] = '{12'd4, 100, 1'b0, 1'b0, 4 + CKS_EXTRA, RAM_LAT + 2, 1'b1,
                    (CKS_EXTRA != 0) ? 16'h0406 : 16'h0103};
        vecs[1] = '{12'd1, 100, 1'b1, 1'b0, 1 + CKS_EXTRA, RAM_LAT + 2, 1'b0, 16'h0000};
        vecs[2] = '{12'd7, 50,  1'b1, 1'b0, 7 + CKS_EXTRA, RAM_LAT + 2, 1'b0, 16'h0000};
        vecs[3] = '{12'd6, 100, 1'b0, 1'b1, 6 + CKS_EXTRA, RAM_LAT + 2, 1'b1,
                    (CKS_EXTRA != 0) ? 16'h060F : 16'h0105};
        vecs[4] = '{12'd5, 30,  1'b0, 1'b0, 5 + CKS_EXTRA, RAM_LAT + 2, 1'b1,
                    (CKS_EXTRA != 0) ? 16'h050A : 16'h0104};
        vecs[5] = '{12'd0, 100, 1'b1, 1'b0, 4096 + CKS_EXTRA, RAM_LAT + 2, 1'b0, 16'h0000};

        rst_n = 1'b0; start = 1'b0; n_words = '0; out_ready = 1'b0;
        fill_mem(1'b0);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("reset addr_rst", 32'(addr_rst), 32'd1);
        check("reset outputs low", 32'({addr_clk, out_valid, out_last, busy, done}), 32'd0);
        check("reset out_data", 32'(out_data), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("idle after reset", 32'({addr_rst, busy, out_valid}), 32'b100);

        for (int v = 0; v < 6; v++) begin
            fill_mem(vecs[v].rand_mem);
            run_frame(vecs[v].n, vecs[v].rdy_pct, vecs[v].mid_start, n_x, lat, lw);
            check($sformatf("vec%0d length", v), 32'(n_x), 32'(vecs[v].exp_len));
            check($sformatf("vec%0d first valid latency", v), 32'(lat), 32'(vecs[v].exp_lat));
            if (vecs[v].chk_last) check($sformatf("vec%0d last word", v), 32'(lw), 32'(vecs[v].exp_last));
        end

        // start arriving while the sequencer shows done must be ignored.
        fill_mem(1'b0);
        run_frame(12'd2, 100, 1'b0, n_x, lat, lw);
        start = 1'b1; n_words = 12'd3;
        @(negedge clk); start = 1'b0;
        check("start during done ignored", 32'({busy, addr_rst}), 32'b01);
        @(negedge clk);
        check("still idle after done", 32'({busy, out_valid}), 32'b00);

        // Reset while a word is pending abandons the frame.
        @(negedge clk); start = 1'b1; n_words = 12'd8; out_ready = 1'b0;
        @(negedge clk); start = 1'b0;
        wait_cnt = 0;
        while (!out_valid && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("reached pending word", 32'(out_valid), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset mid-frame: valid,busy,addr_rst", 32'({out_valid, busy, addr_rst}), 32'b001);
        check("reset mid-frame: counter", 32'(ram_addr), 32'd0);
        @(negedge clk); rst_n = 1'b0;
        bad_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) bad_done = 1;
        end
        check("no done after abandoned frame", 32'(bad_done), 32'd0);
        run_frame(12'd3, 100, 1'b0, n_x, lat, lw);
        check("frame after reset length", 32'(n_x), 32'(3 + CKS_EXTRA));

`ifdef ECHO_RD_CKSUM_EN
        fill_mem(1'b0);
        mem[0] = 16'hFFFF; mem[1] = 16'h0002; mem[2] = 16'h0003;
        run_frame(12'd3, 100, 1'b0, n_x, lat, lw);
        check("checksum frame length", 32'(n_x), 32'd4);
        check("checksum word", 32'(lw), 32'h0004);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/echo_rd_seq.md
# echo_rd_seq

Readout sequencer for the echo sample buffer. It drives the reset and read-clock inputs of the 12-bit free-running read-address counter and captures the buffer RAM output at each address. It then streams the words to the upload path over a valid/ready handshake. The block sits between the acquisition buffer and the upload FIFO/UART framer, and owns the address counter's control pins.

## Interface
- DATA_W, 16, RAM data and output word width
- RAM_LAT, 1, clk cycles from address change to valid ram_dout (1..3)
- clk  in  1  system clock, rising-edge
- rst_n  in  1  reset rst_n, asynchronous, active-high
- start  in  1  one-cycle pulse, begin readout; ignored while busy
- n_words  in  12  words to read, sampled on accepted start; 0 means 4096
- addr_rst  out  1  drives counter reset; 1 holds counter at 0
- addr_clk  out  1  counter clock; counter advances on its falling edge
- ram_dout  in  DATA_W  buffer RAM read data
- out_data  out  DATA_W  output word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts when high with out_valid
- out_last  out  1  final word of frame, qualified by out_valid
- busy  out  1  readout in progress
- done  out  1  one-cycle pulse after final word transfers

## Operation
- All outputs are registered.
- Reset values:
  - addr_rst=1, everything else 0.
  - Reset mid-readout abandons the frame; no done pulse.
- FSM states and transitions:
  - IDLE: addr_rst=1. Accepted start latches last_idx = n_words-1 (mod 4096), clears word count, sets busy, goes to CLR.
  - CLR: one cycle, addr_rst=1. Then WAIT.
  - WAIT: addr_rst=0. Counts RAM_LAT cycles, then CAPT.
  - CAPT: loads out_data from ram_dout, sets out_valid, goes to XFER.
  - XFER: holds out_data/out_valid stable until out_valid&&out_ready.
    - On transfer with count==last_idx: go to DONE, or to CKS if checksum is enabled.
    - Otherwise: increment count, go to STEP.
  - STEP: addr_clk=1 for exactly one cycle. Its fall at the following edge advances the counter. Then WAIT.
  - DONE: done=1 and busy=0 for one cycle, addr_rst=1. Then IDLE.
- Word count is 12 bits. n_words=0 gives 4096 words; the counter wraps to 0 exactly at the end.
- out_last=1 with the final word of the frame.
- start during busy: ignored, no effect on latched n_words.
- start in the same cycle as DONE: ignored. Readout restarts only from IDLE.

## Timing
- Start to first out_valid: 1 (CLR) + RAM_LAT (WAIT) + 1 (CAPT) cycles.
  - out_valid rises RAM_LAT+2 cycles after the start cycle.
- Per-word period with out_ready held high: RAM_LAT+3 cycles (STEP, WAIT, CAPT, XFER).
- addr_clk pulse width: 1 clk. Minimum low time before the next pulse: RAM_LAT+2 clks.
- done: asserted the cycle after the last transfer (or after the checksum word transfer).
- No combinational path from out_ready to out_valid or out_data.

## Configuration
- ECHO_RD_CKSUM_EN defined:
  - After the last data word transfers, state CKS presents one extra word: the sum of all transferred data words mod 2^DATA_W.
  - out_last is asserted on the checksum word only.
  - Frame length is n_words+1.
- ECHO_RD_CKSUM_EN undefined:
  - No CKS state, no accumulator.
  - out_last is on the final data word.

## Structure
- Package echo_rd_pkg holds:
  - the state enum (IDLE, CLR, WAIT, CAPT, XFER, STEP, CKS, DONE);
  - ADDR_W=12;
  - the latency counter width constant.
- Sub-module echo_rd_cksum: accumulator with clear on start and add on each data transfer. Instantiated only under ECHO_RD_CKSUM_EN.

## Test plan
- n_words=4, RAM model returns address+0x100, RAM_LAT=1, out_ready=1:
  - out words 0x100..0x103;
  - out_valid first high 3 cycles after start;
  - out_last on 0x103;
  - done 1 cycle later.
- n_words=0:
  - 4096 words transferred;
  - counter wraps to 0;
  - out_last on word 4095.
- out_ready toggled randomly:
  - out_data stable while stalled;
  - no addr_clk pulse until transfer;
  - all words in order.
- start pulsed mid-frame with a different n_words: frame length unchanged, busy stays high.
- rst_n asserted during XFER: next cycle out_valid=0, busy=0, addr_rst=1; no done; a new start reads from address 0.
- ECHO_RD_CKSUM_EN, n_words=3, data 0xFFFF,0x0002,0x0003:
  - 4th word is 0x0004 with out_last=1.
